cxt_fetch_ingress_arbiter: RTL and testbench

//  Shares the single OoOStation CxtMgt ingress channel (head/data/start/last, valid/ready) between REQ_NUM

---
 rtl/cxt_fetch_ingress_arbiter_pkg.sv | 30 +++
 rtl/cxt_fetch_ingress_arbiter_if.sv | 39 +++
 rtl/cxt_fetch_ingress_arbiter_rr_pick_first.sv | 34 +++
 rtl/cxt_fetch_ingress_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cxt_fetch_ingress_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cxt_fetch_ingress_arbiter_pkg.sv
// Shared definitions for the CxtMgt fetch ingress arbiter: default ingress
// widths and small index helpers used by the arbiter and its picker.
package cxt_fetch_ingress_arbiter_pkg;

    localparam int unsigned CXT_INGRESS_HEAD_WIDTH = 128;
    localparam int unsigned CXT_INGRESS_DATA_WIDTH = 256;
    localparam int unsigned CXT_REQ_NUM_DEF        = 2;

    // Width of a requester index: clog2(n), never below 1.
    function automatic int unsigned req_num_log(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

    // (base + step) mod n, valid for base < n and step <= n.
    function automatic int unsigned rr_wrap_add(input int unsigned base,
                                                input int unsigned step,
                                                input int unsigned n);
        int unsigned sum;
        sum = base + step;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/cxt_fetch_ingress_arbiter_if.sv
// Ingress bundle: per-requester beat inputs on one side, the single shared
// CxtMgt ingress channel (plus source tag) on the other.
interface cxt_fetch_ingress_arbiter_if
    import cxt_fetch_ingress_arbiter_pkg::*;
#(
    parameter int unsigned REQ_NUM     = CXT_REQ_NUM_DEF,
    parameter int unsigned REQ_NUM_LOG = req_num_log(REQ_NUM),
    parameter int unsigned HEAD_WIDTH  = CXT_INGRESS_HEAD_WIDTH,
    parameter int unsigned DATA_WIDTH  = CXT_INGRESS_DATA_WIDTH
);

    logic [REQ_NUM-1:0]            req_valid;
    logic [REQ_NUM*HEAD_WIDTH-1:0] req_head;
    logic [REQ_NUM*DATA_WIDTH-1:0] req_data;
    logic [REQ_NUM-1:0]            req_start;
    logic [REQ_NUM-1:0]            req_last;
    logic [REQ_NUM-1:0]            req_ready;

    logic                          out_valid;
    logic [HEAD_WIDTH-1:0]         out_head;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_start;
    logic                          out_last;
    logic [REQ_NUM_LOG-1:0]        out_src;
    logic                          out_ready;

    // Requester/downstream side (drives beats in, accepts beats out).
    modport master (
        output req_valid, req_head, req_data, req_start, req_last, out_ready,
        input  req_ready, out_valid, out_head, out_data, out_start, out_last, out_src
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_head, req_data, req_start, req_last, out_ready,
        output req_ready, out_valid, out_head, out_data, out_start, out_last, out_src
    );

endinterface

// File: rtl/cxt_fetch_ingress_arbiter_rr_pick_first.sv
// Combinational round-robin picker: first set bit of req_vec_i at or after
// ptr_i, scanning upward and wrapping. Returns one-hot grant and its index.
module cxt_fetch_ingress_arbiter_rr_pick_first
    import cxt_fetch_ingress_arbiter_pkg::*;
#(
    parameter int unsigned REQ_NUM     = CXT_REQ_NUM_DEF,
    parameter int unsigned REQ_NUM_LOG = req_num_log(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]     req_vec_i,
    input  logic [REQ_NUM_LOG-1:0] ptr_i,
    output logic [REQ_NUM-1:0]     grant_oh_o,
    output logic [REQ_NUM_LOG-1:0] grant_idx_o,
    output logic                   grant_vld_o
);

    logic [REQ_NUM_LOG-1:0] idx;

    // Scan from the pointer; the first hit wins and later hits are ignored.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        idx         = '0;
        for (int unsigned off = 0; off < REQ_NUM; off++) begin
            idx = REQ_NUM_LOG'(rr_wrap_add(32'(ptr_i), off, REQ_NUM));
            if (!grant_vld_o && req_vec_i[idx]) begin
                grant_vld_o      = 1'b1;
                grant_idx_o      = idx;
                grant_oh_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cxt_fetch_ingress_arbiter.sv
// Shares the OoOStation CxtMgt ingress channel between REQ_NUM requesters.
// Packet-granular round-robin: a start beat wins arbitration, the grant is
// held until the last beat, then the pointer moves past the owner. Beats go
// through one output register slice and carry the owner's index in out_src.
module cxt_fetch_ingress_arbiter
    import cxt_fetch_ingress_arbiter_pkg::*;
#(
    parameter int unsigned REQ_NUM     = CXT_REQ_NUM_DEF,
    parameter int unsigned REQ_NUM_LOG = req_num_log(REQ_NUM),
    parameter int unsigned HEAD_WIDTH  = CXT_INGRESS_HEAD_WIDTH,
    parameter int unsigned DATA_WIDTH  = CXT_INGRESS_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    cxt_fetch_ingress_arbiter_if.slave    bus,
    output logic                          proto_err
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [REQ_NUM_LOG-1:0] rr_ptr_q, rr_ptr_d;
    logic [REQ_NUM_LOG-1:0] grant_idx_q, grant_idx_d;
    logic                   proto_err_q, proto_err_d;

    logic                   out_valid_q;
    logic [HEAD_WIDTH-1:0]  out_head_q;
    logic [DATA_WIDTH-1:0]  out_data_q;
    logic                   out_start_q;
    logic                   out_last_q;
    logic [REQ_NUM_LOG-1:0] out_src_q;

    logic                   slice_free;
    logic                   accept;
    logic [REQ_NUM_LOG-1:0] sel_idx;
    logic                   sel_start;
    logic                   sel_last;
    logic [HEAD_WIDTH-1:0]  sel_head;
    logic [DATA_WIDTH-1:0]  sel_data;

    logic [REQ_NUM-1:0]     start_cand;
    logic [REQ_NUM-1:0]     pick_oh;
    logic [REQ_NUM_LOG-1:0] pick_idx;
    logic                   pick_vld;

    assign slice_free = !out_valid_q || bus.out_ready;
    assign start_cand = bus.req_valid & bus.req_start;

    cxt_fetch_ingress_arbiter_rr_pick_first #(
        .REQ_NUM     (REQ_NUM),
        .REQ_NUM_LOG (REQ_NUM_LOG)
    ) u_rr_pick (
        .req_vec_i   (start_cand),
        .ptr_i       (rr_ptr_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .grant_vld_o (pick_vld)
    );

    assign sel_head = bus.req_head[32'(sel_idx) * HEAD_WIDTH +: HEAD_WIDTH];
    assign sel_data = bus.req_data[32'(sel_idx) * DATA_WIDTH +: DATA_WIDTH];

    // Grant selection, per-requester ready and next arbitration state.
    // Ready is held low during reset so nothing is accepted into a slice
    // that is being cleared on the same edge.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        proto_err_d   = proto_err_q;
        bus.req_ready = '0;
        sel_idx       = '0;
        accept        = 1'b0;

        case (state_q)
            ST_ARB: begin
                sel_idx = pick_idx;
                if (pick_vld && slice_free && !rst) begin
                    bus.req_ready = pick_oh;
                    accept        = 1'b1;
                end
            end
            ST_LOCK: begin
                sel_idx = grant_idx_q;
                if (slice_free && !rst) begin
                    bus.req_ready[grant_idx_q] = 1'b1;
                    accept                     = bus.req_valid[grant_idx_q];
                end
            end
            default: begin
                sel_idx = '0;
            end
        endcase

        sel_start = bus.req_start[sel_idx];
        sel_last  = bus.req_last[sel_idx];

        if (accept) begin
            if (state_q == ST_ARB) begin
                if (sel_last) begin
                    rr_ptr_d = REQ_NUM_LOG'(rr_wrap_add(32'(sel_idx), 1, REQ_NUM));
                end else begin
                    state_d     = ST_LOCK;
                    grant_idx_d = sel_idx;
                end
            end else begin
                if (sel_start) begin
                    proto_err_d = 1'b1;
                end
                if (sel_last) begin
                    state_d  = ST_ARB;
                    rr_ptr_d = REQ_NUM_LOG'(rr_wrap_add(32'(grant_idx_q), 1, REQ_NUM));
                end
            end
        end
    end

    // Arbitration state register; only moves on an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ARB;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Output slice: load on accept, drain on downstream ready, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_head_q  <= '0;
            out_data_q  <= '0;
            out_start_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_head_q  <= sel_head;
            out_data_q  <= sel_data;
            out_start_q <= sel_start;
            out_last_q  <= sel_last;
            out_src_q   <= sel_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_head  = out_head_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_start = out_start_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
    assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_cxt_fetch_ingress_arbiter.sv
// Self-checking bench for cxt_fetch_ingress_arbiter: accepted beats are
// pushed to a scoreboard and compared as they leave the output slice;
// directed scenarios check grant timing, locking, stalls, errors and reset.
module tb_cxt_fetch_ingress_arbiter;

    localparam int unsigned REQ_NUM     = 2;
    localparam int unsigned REQ_NUM_LOG = 1;
    localparam int unsigned HW          = 128;
    localparam int unsigned DW          = 256;

    typedef struct {
        logic [HW-1:0]          head;
        logic [DW-1:0]          data;
        logic                   start;
        logic                   last;
        logic [REQ_NUM_LOG-1:0] src;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    logic proto_err;

    beat_t       sb_q[$];
    int unsigned out_src_log[$];
    int unsigned out_cyc_log[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    always #5 clk = ~clk;

    cxt_fetch_ingress_arbiter_if #(
        .REQ_NUM     (REQ_NUM),
        .REQ_NUM_LOG (REQ_NUM_LOG),
        .HEAD_WIDTH  (HW),
        .DATA_WIDTH  (DW)
    ) bus ();

    cxt_fetch_ingress_arbiter #(
        .REQ_NUM     (REQ_NUM),
        .REQ_NUM_LOG (REQ_NUM_LOG),
        .HEAD_WIDTH  (HW),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .proto_err (proto_err)
    );

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int unsigned g, input logic v, input logic s,
                           input logic l, input logic [HW-1:0] h);
        bus.req_valid[g]            = v;
        bus.req_start[g]            = s;
        bus.req_last[g]             = l;
        bus.req_head[g*HW +: HW]    = h;
        bus.req_data[g*DW +: DW]    = {h, ~h};
    endtask

    task automatic idle_all();
        for (int unsigned g = 0; g < REQ_NUM; g++) begin
            set_req(g, 1'b0, 1'b0, 1'b0, '0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
        out_src_log.delete();
        out_cyc_log.delete();
    endtask

    // Monitor: pop/compare beats leaving the slice, push beats accepted upstream.
    initial begin
        beat_t              e;
        logic [REQ_NUM-1:0] acc;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid && bus.out_ready) begin
                check_val("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check_val("sb_head",  bus.out_head,  e.head);
                    check_val("sb_data",  bus.out_data,  e.data);
                    check_val("sb_start", bus.out_start, e.start);
                    check_val("sb_last",  bus.out_last,  e.last);
                    check_val("sb_src",   bus.out_src,   e.src);
                end
                out_src_log.push_back(32'(bus.out_src));
                out_cyc_log.push_back(cyc);
            end
            acc = bus.req_valid & bus.req_ready;
            check_val("accept_onehot", $countones(acc) <= 1, 1);
            for (int unsigned g = 0; g < REQ_NUM; g++) begin
                if (acc[g]) begin
                    e.head  = bus.req_head[g*HW +: HW];
                    e.data  = bus.req_data[g*DW +: DW];
                    e.start = bus.req_start[g];
                    e.last  = bus.req_last[g];
                    e.src   = REQ_NUM_LOG'(g);
                    sb_q.push_back(e);
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [REQ_NUM-1:0] acc;
        logic [HW-1:0]      hd [REQ_NUM];
        int unsigned        exp3 [5];
        int unsigned        exp4 [4];

        exp3 = '{0, 1, 1, 1, 0};
        exp4 = '{0, 0, 0, 1};
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        idle_all();

        // Reset state and a single-beat packet.
        do_reset();
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", bus.out_valid, 0);
        check_val("rst_ready",     bus.req_ready, 0);
        check_val("rst_proto_err", proto_err, 0);
        check_val("rst_rr_ptr",    dut.rr_ptr_q, 0);
        check_val("rst_state",     dut.state_q, 0);
        check_val("rst_out_head",  bus.out_head, 0);
        tick();
        set_req(0, 1'b1, 1'b1, 1'b1, 'h11);
        @(negedge clk);
        check_val("t1_ready", bus.req_ready, 2'b01);
        tick();
        idle_all();
        @(negedge clk);
        check_val("t1_out_valid", bus.out_valid, 1);
        check_val("t1_out_head",  bus.out_head, 'h11);
        check_val("t1_out_src",   bus.out_src, 0);
        check_val("t1_rr_ptr",    dut.rr_ptr_q, 1);
        tick();
        @(negedge clk);
        check_val("t1_drained", bus.out_valid, 0);

        // Round-robin with both requesters streaming single-beat packets.
        do_reset();
        bus.out_ready = 1'b1;
        hd[0] = 'h200;
        hd[1] = 'h300;
        set_req(0, 1'b1, 1'b1, 1'b1, hd[0]);
        set_req(1, 1'b1, 1'b1, 1'b1, hd[1]);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            tick();
            for (int unsigned g = 0; g < REQ_NUM; g++) begin
                if (acc[g]) begin
                    hd[g] = hd[g] + 1;
                    set_req(g, 1'b1, 1'b1, 1'b1, hd[g]);
                end
            end
        end
        idle_all();
        tick();
        tick();
        check_val("t2_count", out_src_log.size(), 8);
        for (int unsigned k = 0; k < 8 && k < out_src_log.size(); k++) begin
            check_val("t2_src", out_src_log[k], k % 2);
            check_val("t2_no_gap", out_cyc_log[k] - out_cyc_log[0], k);
        end

        // Packet lock: req1 3-beat packet holds off req0.
        do_reset();
        bus.out_ready = 1'b1;
        set_req(0, 1'b1, 1'b1, 1'b1, 'h30);
        @(negedge clk);
        check_val("t3_first_req0", bus.req_ready, 2'b01);
        tick();
        set_req(0, 1'b1, 1'b1, 1'b1, 'h31);
        set_req(1, 1'b1, 1'b1, 1'b0, 'h40);
        @(negedge clk);
        check_val("t3_grant_req1", bus.req_ready, 2'b10);
        tick();
        set_req(1, 1'b1, 1'b0, 1'b0, 'h41);
        @(negedge clk);
        check_val("t3_lock_mid", bus.req_ready, 2'b10);
        tick();
        set_req(1, 1'b1, 1'b0, 1'b1, 'h42);
        @(negedge clk);
        check_val("t3_lock_last", bus.req_ready, 2'b10);
        tick();
        set_req(1, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check_val("t3_req0_next", bus.req_ready, 2'b01);
        tick();
        idle_all();
        tick();
        tick();
        check_val("t3_count", out_src_log.size(), 5);
        for (int unsigned k = 0; k < 5 && k < out_src_log.size(); k++) begin
            check_val("t3_src_seq", out_src_log[k], exp3[k]);
        end

        // Backpressure mid-packet.
        do_reset();
        bus.out_ready = 1'b1;
        set_req(0, 1'b1, 1'b1, 1'b0, 'h60);
        set_req(1, 1'b1, 1'b1, 1'b1, 'h70);
        tick();
        set_req(0, 1'b1, 1'b0, 1'b0, 'h61);
        tick();
        set_req(0, 1'b1, 1'b0, 1'b1, 'h62);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("t4_stall_ready", bus.req_ready, 2'b00);
            check_val("t4_stall_valid", bus.out_valid, 1);
            check_val("t4_stall_head",  bus.out_head, 'h61);
            check_val("t4_stall_last",  bus.out_last, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_val("t4_resume", bus.req_ready, 2'b01);
        tick();
        set_req(0, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check_val("t4_req1_after", bus.req_ready, 2'b10);
        tick();
        idle_all();
        tick();
        tick();
        check_val("t4_sb_empty", sb_q.size(), 0);
        check_val("t4_count", out_src_log.size(), 4);
        for (int unsigned k = 0; k < 4 && k < out_src_log.size(); k++) begin
            check_val("t4_src_seq", out_src_log[k], exp4[k]);
        end

        // Protocol error: start beat inside a locked packet.
        do_reset();
        bus.out_ready = 1'b1;
        set_req(0, 1'b1, 1'b1, 1'b0, 'h80);
        tick();
        set_req(0, 1'b1, 1'b1, 1'b0, 'h81);
        @(negedge clk);
        check_val("t5_err_beat_ready", bus.req_ready, 2'b01);
        check_val("t5_no_err_yet", proto_err, 0);
        tick();
        set_req(0, 1'b1, 1'b0, 1'b1, 'h82);
        @(negedge clk);
        check_val("t5_proto_err", proto_err, 1);
        check_val("t5_fwd_head",  bus.out_head, 'h81);
        check_val("t5_fwd_start", bus.out_start, 1);
        tick();
        idle_all();
        tick();
        tick();
        @(negedge clk);
        check_val("t5_sticky", proto_err, 1);
        check_val("t5_state_arb", dut.state_q, 0);
        do_reset();
        @(negedge clk);
        check_val("t5_cleared", proto_err, 0);

        // Reset during a locked packet.
        do_reset();
        bus.out_ready = 1'b1;
        set_req(0, 1'b1, 1'b1, 1'b1, 'h8f);
        tick();
        set_req(0, 1'b0, 1'b0, 1'b0, '0);
        set_req(1, 1'b1, 1'b1, 1'b0, 'h90);
        tick();
        set_req(1, 1'b1, 1'b0, 1'b0, 'h91);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_lock_state", dut.state_q, 1);
        check_val("t6_rst_ready", bus.req_ready, 2'b00);
        tick();
        rst = 1'b0;
        idle_all();
        @(negedge clk);
        check_val("t6_out_valid", bus.out_valid, 0);
        check_val("t6_state",     dut.state_q, 0);
        check_val("t6_rr_ptr",    dut.rr_ptr_q, 0);
        check_val("t6_proto_err", proto_err, 0);
        tick();
        set_req(1, 1'b1, 1'b1, 1'b1, 'hA0);
        @(negedge clk);
        check_val("t6_fresh_ready", bus.req_ready, 2'b10);
        tick();
        idle_all();
        @(negedge clk);
        check_val("t6_fresh_valid", bus.out_valid, 1);
        check_val("t6_fresh_src",   bus.out_src, 1);
        check_val("t6_fresh_head",  bus.out_head, 'hA0);
        tick();
        tick();
        check_val("sb_final_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
